// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO status blocks.
// Holds the core-sequencer state encoding and the default parameter values
// used by core_status_gpio and blink_counter.
package gpio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START_CORES = 3'd1,
        ST_WAIT_DONE   = 3'd2,
        ST_DONE        = 3'd3,
        ST_ERROR       = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_CORES      = 4;
    localparam int unsigned DEF_BLINK_W        = 24;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/core_status_gpio_blink_counter.sv
// blink_counter: free-running BLINK_W-bit counter that wraps; its MSB is the
// blink phase shared by the status LEDs.
// Ports:
//   clk   - clock
//   rst   - synchronous, active-high reset (counter to zero)
//   blink - counter MSB
module blink_counter
    import gpio_pkg::*;
#(
    parameter int unsigned BLINK_W = DEF_BLINK_W
) (
    input  logic clk,
    input  logic rst,
    output logic blink
);

    logic [BLINK_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + BLINK_W'(1);
        end
    end

    assign blink = count[BLINK_W-1];

endmodule

// File: rtl/core_status_gpio.sv
// core_status_gpio: launches NUM_CORES accelerator cores with a one-cycle
// start pulse, latches each core's done flag, and drives per-core status LEDs
// plus done/error LEDs. A watchdog moves to ERROR if not every core reports
// done within TIMEOUT_CYCLES cycles of entering WAIT_DONE.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - run request (honoured in IDLE, DONE and ERROR)
//   core_done   - per-core done (level or pulse), latched only in WAIT_DONE
//   core_start  - one-cycle all-ones start pulse to the cores
//   busy        - high in START_CORES and WAIT_DONE
//   led         - per-core status: on = done, blinking = pending/timed out
//   led_done    - all cores finished
//   led_err     - watchdog expired
//   done_pulse  - one-cycle pulse on entry to DONE
module core_status_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_CORES      = DEF_NUM_CORES,
    parameter int unsigned BLINK_W        = DEF_BLINK_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_start,
    output logic                 busy,
    output logic [NUM_CORES-1:0] led,
    output logic                 led_done,
    output logic                 led_err,
    output logic                 done_pulse
);

    localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nx;
    logic [NUM_CORES-1:0] done_seen, done_seen_nx;
    logic [CNT_W-1:0]     tcount, tcount_nx;
    logic [NUM_CORES-1:0] core_start_nx, led_nx;
    logic                 busy_nx, led_done_nx, led_err_nx, done_pulse_nx;
    logic                 blink;
    logic                 all_done;

    blink_counter #(.BLINK_W(BLINK_W)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .blink (blink)
    );

    // Includes this cycle's core_done so a final done is not lost to a
    // timeout landing in the same cycle.
    assign all_done = &(done_seen | core_done);

    always_comb begin
        state_nx     = state;
        done_seen_nx = done_seen;
        tcount_nx    = tcount;

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nx = ST_START_CORES;
            end
            ST_START_CORES: begin
                done_seen_nx = '0;
                tcount_nx    = '0;
                state_nx     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                done_seen_nx = done_seen | core_done;
                if (tcount != '1) tcount_nx = tcount + CNT_W'(1);
                if (all_done) begin
                    state_nx = ST_DONE;
                end else if (tcount == CNT_LAST) begin
                    state_nx = ST_ERROR;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_comb begin
        core_start_nx = '0;
        busy_nx       = 1'b0;
        led_nx        = '0;
        led_done_nx   = 1'b0;
        led_err_nx    = 1'b0;
        done_pulse_nx = 1'b0;

        unique case (state_nx)
            ST_START_CORES: begin
                core_start_nx = '1;
                busy_nx       = 1'b1;
            end
            ST_WAIT_DONE: begin
                busy_nx = 1'b1;
                led_nx  = done_seen_nx | {NUM_CORES{blink}};
            end
            ST_DONE: begin
                led_nx        = '1;
                led_done_nx   = 1'b1;
                done_pulse_nx = (state != ST_DONE);
            end
            ST_ERROR: begin
                led_nx     = done_seen_nx | {NUM_CORES{~blink}};
                led_err_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            done_seen  <= '0;
            tcount     <= '0;
            core_start <= '0;
            busy       <= 1'b0;
            led        <= '0;
            led_done   <= 1'b0;
            led_err    <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            done_seen  <= done_seen_nx;
            tcount     <= tcount_nx;
            core_start <= core_start_nx;
            busy       <= busy_nx;
            led        <= led_nx;
            led_done   <= led_done_nx;
            led_err    <= led_err_nx;
            done_pulse <= done_pulse_nx;
        end
    end

endmodule

// File: tb/tb_core_status_gpio.sv
// Self-checking bench for core_status_gpio (4 cores, 3-bit blink, timeout 20).
// A behavioural model tracks run phase, latched done mask, wait length and
// blink phase; each scenario task compares the DUT against it.
module tb_core_status_gpio;

    localparam int TO = 20;
    localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WAIT = 2, PH_DONE = 3, PH_ERR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] core_done = '0;
    logic [3:0] core_start, led;
    logic       busy, led_done, led_err, done_pulse;

    core_status_gpio #(.NUM_CORES(4), .BLINK_W(3), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .core_done(core_done),
        .core_start(core_start), .busy(busy), .led(led), .led_done(led_done),
        .led_err(led_err), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int         m_phase = PH_IDLE;
    logic [3:0] m_seen  = '0;
    int         m_waited = 0;
    int         m_bcnt  = 0;
    logic [11:0] exp_vec = '0;

    wire [11:0] obs = {core_start, busy, led, led_done, led_err, done_pulse};

    // Drive one cycle of inputs, advance the model across the clock edge,
    // then settle 1 time unit past the edge for sampling.
    task automatic step(input logic r, input logic s, input logic [3:0] cd);
        logic       bl;
        logic       entered;
        logic [3:0] e_led;
        rst = r; start = s; core_done = cd;
        @(posedge clk);
        bl = m_bcnt[2];
        m_bcnt = (m_bcnt + 1) % 8;
        entered = 1'b0;
        if (r) begin
            m_phase = PH_IDLE; m_seen = '0; m_waited = 0; m_bcnt = 0;
        end else begin
            case (m_phase)
                PH_LAUNCH: begin
                    m_phase = PH_WAIT; m_seen = '0; m_waited = 0;
                end
                PH_WAIT: begin
                    m_seen = m_seen | cd;
                    if (m_seen == 4'hF) begin
                        m_phase = PH_DONE; entered = 1'b1;
                    end else if (m_waited == TO - 1) begin
                        m_phase = PH_ERR;
                    end else begin
                        m_waited++;
                    end
                end
                default: if (s) m_phase = PH_LAUNCH;
            endcase
        end
        case (m_phase)
            PH_WAIT: e_led = m_seen | {4{bl}};
            PH_ERR:  e_led = m_seen | {4{~bl}};
            PH_DONE: e_led = 4'hF;
            default: e_led = 4'h0;
        endcase
        exp_vec = {(m_phase == PH_LAUNCH) ? 4'hF : 4'h0,
                   (m_phase == PH_LAUNCH || m_phase == PH_WAIT),
                   e_led, (m_phase == PH_DONE), (m_phase == PH_ERR), entered};
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'h0);
            n_checks++;
            if (obs !== 12'h000 || obs !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 12'h000);
            end
        end
    endtask

    task automatic test_sequential_done();
        logic [3:0] pat [6] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
        step(1'b0, 1'b1, 4'h0);
        n_checks++;
        if (core_start !== 4'hF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_launch got start=%b busy=%b exp start=1111 busy=1", core_start, busy);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, pat[i]);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL seq_done cyc=%0d got=%b exp=%b", i, obs, exp_vec);
            end
            // one cycle after the 4th done (driven at i=4) -> done pulse
            if (i == 4) begin
                n_checks++;
                if (led_done !== 1'b1 || done_pulse !== 1'b1 || led !== 4'hF) begin
                    n_fail++;
                    $display("FAIL seq_done_latency got ld=%b dp=%b led=%b exp 1 1 1111",
                             led_done, done_pulse, led);
                end
            end
        end
        n_checks++;
        if (done_pulse !== 1'b0 || led_done !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_done_hold got dp=%b ld=%b exp dp=0 ld=1", done_pulse, led_done);
        end
    endtask

    task automatic test_ignore_in_start();
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'h0);
            n_checks++;
            if (obs !== exp_vec || led_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_start cyc=%0d got=%b exp=%b", i, obs, exp_vec);
            end
        end
        step(1'b0, 1'b0, 4'hF);
        n_checks++;
        if (obs !== exp_vec || done_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start_done got=%b exp=%b", obs, exp_vec);
        end
    endtask

    task automatic test_timeout();
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);   // now first WAIT_DONE cycle
        for (int k = 1; k <= 27; k++) begin
            step(1'b0, 1'b0, (k == 1) ? 4'b0101 : 4'b0000);
            n_checks++;
            if (obs !== exp_vec || led_err !== (k >= TO)) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%b exp=%b err_exp=%0d", k, obs, exp_vec, k >= TO);
            end
            if (k >= TO) begin
                n_checks++;
                if (led[0] !== 1'b1 || led[2] !== 1'b1 || led[1] !== led[3]) begin
                    n_fail++;
                    $display("FAIL timeout_leds k=%0d got led=%b", k, led);
                end
            end
        end
    endtask

    task automatic test_restart_from_error();
        step(1'b0, 1'b1, 4'h0);
        n_checks++;
        if (core_start !== 4'hF || led_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_err got start=%b err=%b busy=%b exp 1111 0 1", core_start, led_err, busy);
        end
        step(1'b0, 1'b1, 4'h0);
        n_checks++;
        if (core_start !== 4'h0 || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL restart_err_single got=%b exp=%b", obs, exp_vec);
        end
    endtask

    task automatic test_done_beats_timeout();
        // currently in the first WAIT_DONE cycle (k=0)
        for (int k = 0; k <= 21; k++) begin
            step(1'b0, 1'b0, (k == 0) ? 4'b0111 : (k == TO - 1) ? 4'b1000 : 4'b0000);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL done_vs_timeout k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
        n_checks++;
        if (led_err !== 1'b0 || led_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_priority got err=%b ld=%b exp err=0 ld=1", led_err, led_done);
        end
    endtask

    task automatic test_restart_from_done();
        step(1'b0, 1'b1, 4'h0);
        n_checks++;
        if (core_start !== 4'hF || led_done !== 1'b0 || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL restart_done got=%b exp=%b", obs, exp_vec);
        end
    endtask

    task automatic test_reset_mid_wait();
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h2);
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h5);
        n_checks++;
        if (obs !== 12'h000 || obs !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid_wait got=%b exp=%b", obs, 12'h000);
        end
        step(1'b0, 1'b0, 4'hF);
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_then_idle got=%b exp=%b", obs, 12'h000);
        end
    endtask

    task automatic test_random();
        logic       r, s;
        logic [3:0] cd;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 9) == 0);
            for (int b = 0; b < 4; b++) cd[b] = ($urandom_range(0, 22) == 0);
            step(r, s, cd);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random i=%0d rst=%b start=%b cd=%b got=%b exp=%b",
                         i, r, s, cd, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential_done();
        test_ignore_in_start();
        test_timeout();
        test_restart_from_error();
        test_done_beats_timeout();
        test_restart_from_done();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_status_gpio.md
Name: core_status_gpio

Overview:
Parametrised successor to the fixed four-LED GPIO sequencer. It launches NUM_CORES accelerator cores, tracks each core's completion, and drives one status LED per core plus done and error LEDs. It runs a real start/done handshake with a timeout watchdog instead of free-running through states. It sits between the top-level control and the board GPIO pins.

Parameters:
NUM_CORES, 4, number of cores/status LEDs (1..32)
BLINK_W, 24, width of free-running blink counter; blink phase = counter MSB
TIMEOUT_CYCLES, 1000000, max cycles in WAIT_DONE before error (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  run request, sampled in IDLE/DONE/ERROR states
core_done  input  NUM_CORES  per-core done, level or pulse, sticky-latched
core_start  output  NUM_CORES  one-cycle start pulse to all cores
busy  output  1  high in START_CORES and WAIT_DONE
led  output  NUM_CORES  per-core status LED
led_done  output  1  all-cores-done LED
led_err  output  1  timeout LED
done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- All outputs registered. Reset values: core_start=0, busy=0, led=0, led_done=0, led_err=0, done_pulse=0, state=IDLE, done_seen=0, timeout counter=0, blink counter=0.
- Reset mid-operation returns the block to IDLE next cycle. No core_start pulse is issued.
- Blink counter: free-running BLINK_W bits, wraps. blink = MSB.
- States: IDLE, START_CORES, WAIT_DONE, DONE, ERROR. Encoded as a 3-bit localparam enum.
- IDLE: led=0, led_done=0, led_err=0. start=1 -> START_CORES.
- START_CORES, exactly 1 cycle:
  - core_start = all ones for this cycle only.
  - done_seen cleared; timeout counter cleared; busy=1.
  - Next state: WAIT_DONE.
  - core_done in this cycle is ignored.
- WAIT_DONE:
  - done_seen |= core_done each cycle.
  - led[i] = 1 if done_seen[i], else blink.
  - Counter increments each cycle.
  - If (done_seen | core_done) is all ones -> DONE. Done takes priority over timeout in the same cycle.
  - Else if counter == TIMEOUT_CYCLES-1 -> ERROR.
  - start is ignored.
- Latency: all cores done in cycle N -> led_done=1 and done_pulse=1 in cycle N+1.
- DONE:
  - led = all ones, led_done=1, busy=0.
  - done_pulse is high only on the first DONE cycle.
  - Holds until start=1 -> START_CORES (led_done drops on entry).
- ERROR:
  - led_err=1.
  - led[i] = 1 for done cores; inverse blink (!blink) for cores that timed out.
  - start=1 -> START_CORES, which clears led_err.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates (never wraps).
- core_done bits asserted outside WAIT_DONE have no effect.

Decomposition:
- Shared package gpio_pkg holds the state enum localparams and default parameter constants.
- One natural sub-module: blink_counter (parametrised BLINK_W free-running counter exposing its MSB). It is reusable for other GPIO blocks.

Test Plan:
Bench uses NUM_CORES=4, BLINK_W=3, TIMEOUT_CYCLES=20.
1. Reset, then idle 10 cycles -> all outputs 0; state IDLE; no core_start.
2. start pulse, then core_done=4'b0001,0010,0100,1000 pulsed on successive cycles -> core_start=4'b1111 for 1 cycle; led lights core by core, undone cores toggling every 4 cycles; led_done=1 and done_pulse=1 one cycle after the 4th done; led=4'b1111.
3. start, core_done held 4'b1111 during START_CORES only -> ignored; no DONE. Then core_done=4'b1111 in WAIT -> DONE next cycle.
4. start; only cores 0,2 done; wait 20 cycles -> led_err=1 exactly 20 cycles after WAIT entry; led[0]=led[2]=1; led[1],led[3] blinking inverted.
5. Final-core done in the same cycle the counter hits 19 -> DONE, led_err stays 0.
6. rst asserted mid-WAIT_DONE, and start issued from ERROR and from DONE -> rst gives all outputs 0 the next cycle; restart gives a single core_start pulse with led_err/led_done cleared.
